// File: rtl/seek_seq_pkg.sv
// seek_seq_pkg: shared state encoding, fault codes and defaults for the seek sequencer.
package seek_seq_pkg;
  typedef enum logic [2:0] {IDLE, EVAL, SETUP, GO, WAIT_DROP, WAIT_RDY, FAULT} state_t;
  localparam logic [1:0] FC_NONE = 2'd0;
  localparam logic [1:0] FC_RANGE = 2'd1;
  localparam logic [1:0] FC_ACK_TO = 2'd2;
  localparam logic [1:0] FC_SEEK_TO = 2'd3;
  localparam int MAX_CYL_DEFAULT = 202;
endpackage

// File: rtl/seek_sequencer_timer.sv
// usec_timer: loadable 16-bit down-counter; expired rises the cycle after the count sits at zero.
module usec_timer (
  input  logic        clkenbl_1usec,
  input  logic        reset,
  input  logic        load,
  input  logic [15:0] load_val,
  output logic [15:0] value,
  output logic        expired
);
  always_ff @(posedge clkenbl_1usec or negedge reset)
    if (!reset) begin
      value <= '0;
      expired <= 1'b0;
    end else if (load) begin
      value <= load_val;
      expired <= 1'b0;
    end else begin
      expired <= value == '0;
      if (value != '0) value <= value - 1'b1;
    end
endmodule

// File: rtl/seek_sequencer.sv
// seek_sequencer: steps the emulated head to a target cylinder with 10/20-mil access strobes.
module seek_sequencer
  import seek_seq_pkg::*;
#(
  parameter int MAX_CYL = MAX_CYL_DEFAULT,
  parameter int SETUP_US = 2,
  parameter int GO_US = 2,
  parameter int ACK_TIMEOUT_US = 100,
  parameter int SEEK_TIMEOUT_US = 50000
) (
  input  logic       clkenbl_1usec,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] target_cyl,
  input  logic [7:0] cur_cyl,
  input  logic       access_rdy,
  input  logic       selected_ready,
  output logic       acc_go_l,
  output logic       acc_rev_l,
  output logic       ten_twenty_l,
  output logic       busy,
  output logic       done,
  output logic       fault,
  output logic [1:0] fault_code
);
  localparam logic [8:0] MAX_LIM = 9'(MAX_CYL);
  localparam logic [15:0] SETUP_LD = 16'(SETUP_US - 1);
  localparam logic [15:0] GO_LD = 16'(GO_US - 1);
  localparam logic [15:0] ACK_LD = 16'(ACK_TIMEOUT_US - 1);
  localparam logic [15:0] SEEK_LD = 16'(SEEK_TIMEOUT_US - 1);

  state_t state, nxt;
  logic [7:0] target;
  logic [8:0] diff, mag;
  logic [1:0] code;
  logic [15:0] load_val, count;
  logic accept, load, expired;

  assign diff = {1'b0, target} - {1'b0, cur_cyl};
  assign mag = diff[8] ? -diff : diff;
  assign accept = start && selected_ready && access_rdy && (state == IDLE || state == FAULT);
  assign load = nxt != state;

  // Intervals end while the count reads zero; timeouts wait for the sticky expiry one cycle later.
  always_comb begin
    nxt = state;
    code = FC_NONE;
    if (state != IDLE && state != FAULT && !selected_ready) begin
      nxt = FAULT;
      code = FC_SEEK_TO;
    end else
      case (state)
        IDLE, FAULT: nxt = accept ? EVAL : state;
        EVAL: begin
          nxt = {1'b0, target} > MAX_LIM ? FAULT : diff == '0 ? IDLE : SETUP;
          code = {1'b0, target} > MAX_LIM ? FC_RANGE : FC_NONE;
        end
        SETUP: nxt = count == '0 ? GO : SETUP;
        GO: nxt = count == '0 ? WAIT_DROP : GO;
        WAIT_DROP: begin
          nxt = !access_rdy ? WAIT_RDY : expired ? FAULT : WAIT_DROP;
          code = FC_ACK_TO;
        end
        WAIT_RDY: begin
          nxt = access_rdy ? EVAL : expired ? FAULT : WAIT_RDY;
          code = FC_SEEK_TO;
        end
        default: nxt = IDLE;
      endcase
  end

  always_comb
    load_val = nxt == SETUP ? SETUP_LD :
               nxt == GO ? GO_LD :
               nxt == WAIT_DROP ? ACK_LD :
               nxt == WAIT_RDY ? SEEK_LD : '0;

  usec_timer timer (
    .clkenbl_1usec(clkenbl_1usec),
    .reset(reset),
    .load(load),
    .load_val(load_val),
    .value(count),
    .expired(expired)
  );

  always_ff @(posedge clkenbl_1usec or negedge reset)
    if (!reset) begin
      state <= IDLE;
      target <= '0;
      acc_go_l <= 1'b1;
      acc_rev_l <= 1'b1;
      ten_twenty_l <= 1'b1;
      busy <= 1'b0;
      done <= 1'b0;
      fault <= 1'b0;
      fault_code <= FC_NONE;
    end else begin
      state <= nxt;
      acc_go_l <= nxt != GO;
      busy <= nxt != IDLE && nxt != FAULT;
      done <= state == EVAL && nxt == IDLE;
      if (accept) begin
        target <= target_cyl;
        fault <= 1'b0;
        fault_code <= FC_NONE;
      end
      if (state == EVAL && nxt == SETUP) begin
        acc_rev_l <= !diff[8];
        ten_twenty_l <= mag > 9'd1;
      end
      if (nxt == FAULT && state != FAULT) begin
        fault <= 1'b1;
        fault_code <= code;
      end
    end
endmodule
